// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : ID/EX pipeline register of the 5-stage RV32I core. Captures the
//            decoded control bundles, operands, PC, immediate and register
//            indices into EX. Detects load-use hazards (one bubble, stall of
//            PC and IF/ID), honours EX flushes and downstream memory stalls.
// Ports    : clk, rst_n (async, active-low)
//            id_*_i          decode-stage instruction slot
//            ex_flush_i      redirect from EX (loads a bubble)
//            mem_busy_i      downstream stall (hold every EX register)
//            ex_*_o          registered EX slot
//            stall_if_id_o   combinational stall of PC and IF/ID
//            bubble_cnt_o    number of load-use bubbles inserted
// Config   : ID_EX_BUBBLE_CNT_EN defined -> bubble counter present;
//            undefined -> bubble_cnt_o tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_ex_i,
  input  logic [2:0]       id_m_i,
  input  logic [2:0]       id_wb_i,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             ex_flush_i,
  input  logic             mem_busy_i,
  output logic             ex_valid_o,
  output logic [4:0]       ex_ex_o,
  output logic [2:0]       ex_m_o,
  output logic [2:0]       ex_wb_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_rs1_data_o,
  output logic [XLEN-1:0]  ex_rs2_data_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic [4:0]       ex_rd_o,
  output logic             stall_if_id_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic take_bubble;
  logic load_bubble;

  // A load writing x0 never produces a value worth waiting for.
  assign ex_is_load = ex_valid_o & ex_wb_o[2] & (ex_wb_o[1:0] == 2'b11)
                    & (ex_rd_o != 5'd0);
  assign rs1_hit    = id_rs1_used_i & (id_rs1_i == ex_rd_o);
  assign rs2_hit    = id_rs2_used_i & (id_rs2_i == ex_rd_o);
  assign load_use   = ex_is_load & id_valid_i & (rs1_hit | rs2_hit);

  // Flush wins over everything and does not stall: upstream flushes IF/ID.
  assign stall_if_id_o = ~ex_flush_i & (mem_busy_i | load_use);

  // Load-use bubble only when neither a flush nor a memory hold preempts it.
  assign take_bubble = ~ex_flush_i & ~mem_busy_i & load_use;
  assign load_bubble = ex_flush_i | take_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o    <= 1'b0;
      ex_ex_o       <= '0;
      ex_m_o        <= '0;
      ex_wb_o       <= '0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
    end else if (load_bubble) begin
      ex_valid_o    <= 1'b0;
      ex_ex_o       <= '0;
      ex_m_o        <= '0;
      ex_wb_o       <= '0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_o      <= '0;
      ex_rs2_o      <= '0;
      ex_rd_o       <= '0;
    end else if (!mem_busy_i) begin
      // An empty ID slot carries no side effects: kill its control bits.
      ex_valid_o    <= id_valid_i;
      ex_ex_o       <= id_valid_i ? id_ex_i : 5'd0;
      ex_m_o        <= id_valid_i ? id_m_i  : 3'd0;
      ex_wb_o       <= id_valid_i ? id_wb_i : 3'd0;
      ex_pc_o       <= id_pc_i;
      ex_rs1_data_o <= id_rs1_data_i;
      ex_rs2_data_o <= id_rs2_data_i;
      ex_imm_o      <= id_imm_i;
      ex_rs1_o      <= id_rs1_i;
      ex_rs2_o      <= id_rs2_i;
      ex_rd_o       <= id_rd_i;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;

  // Free-running modulo counter; wraps naturally from all-ones to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (take_bubble) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bubble_cnt_o = bubble_cnt;
`else
  assign bubble_cnt_o = '0;
`endif

endmodule
`default_nettype wire
